// File: rtl/serial_word_deserializer.sv
// serial_word_deserializer
// Receives framed serial words: start bit (0), WIDTH data bits LSB-first,
// optional even-parity bit, stop bit (1). Completed words are held in an
// output register with a valid/ready handshake. Error pulses are one cycle.
// Optional feature macro: DESER_PARITY_EN adds the parity bit and check.
module serial_word_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] shreg_r;
  logic [CW-1:0]    bit_cnt_r;
  logic [WIDTH-1:0] dout_r;
  logic             dout_valid_r;
  logic             busy_r;
  logic             frame_err_r;
  logic             overrun_r;
  logic             handshake_s;
  logic             parity_bad_s;

`ifdef DESER_PARITY_EN
  logic             pbit_r;
  logic             parity_err_r;

  // Even parity over data plus parity bit; a set result means a mismatch.
  function automatic logic even_parity_bad(input logic [WIDTH-1:0] data,
                                           input logic pbit);
    even_parity_bad = (^data) ^ pbit;
  endfunction

  // Parity verdict for the word currently in the shift register.
  always_comb begin
    parity_bad_s = even_parity_bad(shreg_r, pbit_r);
  end

  assign parity_err = parity_err_r;
`else
  // Without the parity bit every well-framed word counts as good.
  always_comb begin
    parity_bad_s = 1'b0;
  end

  assign parity_err = 1'b0;
`endif

  // Output handshake completes only while a word is actually held.
  always_comb begin
    handshake_s = dout_valid_r & dout_ready;
  end

  // Frame FSM, shift register, output register and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      shreg_r      <= '0;
      bit_cnt_r    <= '0;
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
`ifdef DESER_PARITY_EN
      pbit_r       <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
`ifdef DESER_PARITY_EN
      parity_err_r <= 1'b0;
`endif
      if (handshake_s) begin
        dout_valid_r <= 1'b0;
      end
      if (din_valid) begin
        case (state_r)
          IDLE: begin
            if (!din) begin
              state_r   <= DATA;
              busy_r    <= 1'b1;
              bit_cnt_r <= '0;
            end
          end
          DATA: begin
            shreg_r   <= {din, shreg_r[WIDTH-1:1]};
            bit_cnt_r <= bit_cnt_r + CW'(1);
            if (bit_cnt_r == LAST_BIT) begin
`ifdef DESER_PARITY_EN
              state_r <= PARITY;
`else
              state_r <= STOP;
`endif
            end
          end
`ifdef DESER_PARITY_EN
          PARITY: begin
            pbit_r  <= din;
            state_r <= STOP;
          end
`endif
          STOP: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            if (!din) begin
              frame_err_r <= 1'b1;
            end else if (parity_bad_s) begin
`ifdef DESER_PARITY_EN
              parity_err_r <= 1'b1;
`endif
            end else if (!dout_valid_r || handshake_s) begin
              dout_r       <= shreg_r;
              dout_valid_r <= 1'b1;
            end else begin
              overrun_r <= 1'b1;
            end
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign busy       = busy_r;
  assign frame_err  = frame_err_r;
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Self-checking bench for serial_word_deserializer (WIDTH=8).
// Frame records drive a small reference model; expected outcomes go into a
// scoreboard queue at frame start and are popped after the stop-bit edge.
module tb_serial_word_deserializer;

  localparam int WIDTH = 8;
  localparam int K_WORD = 0;
  localparam int K_FERR = 1;
  localparam int K_PERR = 2;
  localparam int K_OVR  = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             din;
  logic             din_valid;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             busy;
  logic             frame_err;
  logic             parity_err;
  logic             overrun;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       pbit;
    int         gap;
    logic       ready;
  } vec_t;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  vec_t       vecs[$];
  exp_t       sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic       model_valid = 1'b0;
  logic [7:0] model_dout = 8'h00;

  serial_word_deserializer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    din = b;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic gaps(input int n);
    for (int g = 0; g < n; g++) begin
      @(negedge clk);
      din_valid = 1'b0;
      din = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input vec_t v);
    exp_t e;
    logic bad;
`ifdef DESER_PARITY_EN
    bad = (^v.data) ^ v.pbit;
`else
    bad = 1'b0;
`endif
    // start bit, with this frame's ready level applied from the same edge
    @(negedge clk);
    dout_ready = v.ready;
    din = 1'b0;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    if (v.ready) model_valid = 1'b0;
    e.data = v.data;
    if (!v.stop)          e.kind = K_FERR;
    else if (bad)         e.kind = K_PERR;
    else if (!model_valid) e.kind = K_WORD;
    else                  e.kind = K_OVR;
    sb.push_back(e);
    chk("busy_after_start", busy, 1);
    gaps(v.gap);
    for (int i = 0; i < WIDTH; i++) begin
      send_bit(v.data[i]);
      gaps(v.gap);
      if (i == 3 && v.gap > 0) chk("busy_in_gap", busy, 1);
    end
`ifdef DESER_PARITY_EN
    send_bit(v.pbit);
    gaps(v.gap);
`endif
    send_bit(v.stop);
    e = sb.pop_front();
    chk("busy_after_stop", busy, 0);
    case (e.kind)
      K_WORD: begin
        chk("word_valid", dout_valid, 1);
        chk("word_data", dout, e.data);
        chk("word_no_ferr", frame_err, 0);
        chk("word_no_ovr", overrun, 0);
        model_valid = 1'b1;
        model_dout = e.data;
      end
      K_FERR: begin
        chk("ferr_pulse", frame_err, 1);
        chk("ferr_no_perr", parity_err, 0);
        chk("ferr_valid_unchanged", dout_valid, model_valid);
      end
      K_PERR: begin
        chk("perr_pulse", parity_err, 1);
        chk("perr_no_ferr", frame_err, 0);
        chk("perr_valid_unchanged", dout_valid, model_valid);
      end
      default: begin
        chk("ovr_pulse", overrun, 1);
        chk("ovr_valid", dout_valid, 1);
        chk("ovr_old_data", dout, model_dout);
      end
    endcase
    // one idle cycle: pulses must drop, held word consumed if ready
    gaps(1);
    if (v.ready) model_valid = 1'b0;
    chk("pulse_ferr_gone", frame_err, 0);
    chk("pulse_perr_gone", parity_err, 0);
    chk("pulse_ovr_gone", overrun, 0);
    chk("valid_after_idle", dout_valid, model_valid);
  endtask

  initial begin
    rst_n = 1'b0;
    din = 1'b1;
    din_valid = 1'b0;
    dout_ready = 1'b0;

    //            data   stop  pbit  gap  ready
    vecs.push_back('{8'hA5, 1'b1, 1'b0, 0, 1'b1});
    vecs.push_back('{8'hA5, 1'b1, 1'b0, 3, 1'b1});
    vecs.push_back('{8'h3C, 1'b0, 1'b0, 0, 1'b1});
    vecs.push_back('{8'h5A, 1'b1, 1'b0, 0, 1'b1});
    vecs.push_back('{8'h11, 1'b1, 1'b0, 0, 1'b0});
    vecs.push_back('{8'h22, 1'b1, 1'b0, 0, 1'b0});
    vecs.push_back('{8'hC3, 1'b1, 1'b0, 1, 1'b0});
`ifdef DESER_PARITY_EN
    vecs.push_back('{8'h07, 1'b1, 1'b1, 0, 1'b1});
    vecs.push_back('{8'h07, 1'b1, 1'b0, 0, 1'b1});
    vecs.push_back('{8'h07, 1'b0, 1'b0, 0, 1'b1});
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_parity_err", parity_err, 0);
    chk("rst_overrun", overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // idle line stays idle
    send_bit(1'b1);
    send_bit(1'b1);
    chk("idle_not_busy", busy, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      send_frame(vecs[i]);
      if (i == 5) begin
        // 0x11 still held after the 0x22 overrun; one-cycle ready drains it
        @(negedge clk);
        din_valid = 1'b0;
        dout_ready = 1'b1;
        @(posedge clk);
        #1;
        model_valid = 1'b0;
        chk("ready_pulse_clears", dout_valid, 0);
        chk("ready_pulse_dout", dout, 8'h11);
        @(negedge clk);
        dout_ready = 1'b0;
      end
    end

    // hold a word, then reset in the middle of a frame
    vecs.delete();
    vecs.push_back('{8'h96, 1'b1, 1'b0, 0, 1'b0});
    send_frame(vecs[0]);
    chk("held_before_reset", dout_valid, model_valid);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    chk("busy_mid_frame", busy, 1);
    @(negedge clk);
    din_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_dout", dout, 0);
    chk("async_rst_valid", dout_valid, 0);
    chk("async_rst_busy", busy, 0);
    model_valid = 1'b0;
    model_dout = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send_bit(1'b1);
    chk("post_rst_idle", busy, 0);
    vecs.delete();
    vecs.push_back('{8'hFF, 1'b1, 1'b1, 0, 1'b1});
`ifdef DESER_PARITY_EN
    vecs[0].pbit = 1'b0;
`endif
    send_frame(vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
